// File: rtl/conv3x3_alu_if.sv
// Bus bundle between conv3x3_alu and its controller / X_buffer neighbour.
// The master drives the control, kernel-load and window inputs; the slave returns the results.
interface conv3x3_alu_if;
    logic               start;
    logic               w_load_en;
    logic [3:0]         w_idx;
    logic [7:0]         w_data;
    logic [23:0]        X_reg1;
    logic [23:0]        X_reg2;
    logic [23:0]        X_reg3;
    logic               ALU_en;
    logic               busy;
    logic               result_valid;
    logic signed [19:0] acc;
    logic [7:0]         pix_out;
    logic [4:0]         col_idx;
    logic               done;

    modport master (
        output start, w_load_en, w_idx, w_data, X_reg1, X_reg2, X_reg3,
        input  ALU_en, busy, result_valid, acc, pix_out, col_idx, done
    );

    modport slave (
        input  start, w_load_en, w_idx, w_data, X_reg1, X_reg2, X_reg3,
        output ALU_en, busy, result_valid, acc, pix_out, col_idx, done
    );
endinterface

// File: rtl/conv3x3_alu.sv
// 3x3 signed-kernel convolution over unsigned 8-bit pixel windows.
// It has a three-stage pipeline (multiply, row sum, total + clamp) and is sequenced by a four-state FSM.
module conv3x3_alu #(
    parameter int unsigned COLS  = 26,
    parameter int unsigned SHIFT = 0
) (
    input logic           clk,
    input logic           rst,
    conv3x3_alu_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [4:0] LastCol = 5'(COLS - 1);

    state_e state_q, state_d;
    logic [4:0] issue_cnt_q;
    logic [1:0] drain_cnt_q;
    logic       alu_en, busy, done;

    logic signed [7:0]  w_q [9];
    logic [23:0]        win [3];
    logic [7:0]         pix [9];

    logic signed [16:0] prod_d [9];
    logic signed [16:0] prod_q [9];
    logic               s1_valid_q;
    logic [4:0]         s1_col_q;

    logic signed [18:0] row_d [3];
    logic signed [18:0] row_q [3];
    logic               s2_valid_q;
    logic [4:0]         s2_col_q;

    logic signed [19:0] acc_d, shifted;
    logic [7:0]         pix_d;
    logic signed [19:0] acc_q;
    logic [7:0]         pix_q;
    logic [4:0]         col_q;
    logic               s3_valid_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (issue_cnt_q == LastCol) state_d = StDrain;
            StDrain: if (drain_cnt_q == 2'd2) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        alu_en = (state_q == StRun);
        busy   = (state_q == StRun) || (state_q == StDrain);
        done   = (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
            drain_cnt_q <= '0;
        end else begin
            issue_cnt_q <= (state_q == StRun)   ? issue_cnt_q + 5'd1 : '0;
            drain_cnt_q <= (state_q == StDrain) ? drain_cnt_q + 2'd1 : '0;
        end
    end

    // Kernel is only writable while idle, so a pass always sees a stable kernel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) w_q[i] <= '0;
        end else if (state_q == StIdle && bus.w_load_en && bus.w_idx < 4'd9) begin
            w_q[bus.w_idx] <= bus.w_data;
        end
    end

    // ---------------- Stage 1: products ----------------
    always_comb begin
        win[0] = bus.X_reg1;
        win[1] = bus.X_reg2;
        win[2] = bus.X_reg3;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                pix[3*r+c] = win[r][8*(2-c) +: 8];
            end
        end
        for (int i = 0; i < 9; i++) begin
            prod_d[i] = 17'($signed({1'b0, pix[i]})) * 17'(w_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_col_q   <= '0;
            for (int i = 0; i < 9; i++) prod_q[i] <= '0;
        end else begin
            s1_valid_q <= alu_en;
            if (alu_en) begin
                s1_col_q <= issue_cnt_q;
                for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
            end
        end
    end

    // ---------------- Stage 2: row sums ----------------
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            row_d[r] = 19'(prod_q[3*r]) + 19'(prod_q[3*r+1]) + 19'(prod_q[3*r+2]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_col_q   <= '0;
            for (int r = 0; r < 3; r++) row_q[r] <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_col_q <= s1_col_q;
                for (int r = 0; r < 3; r++) row_q[r] <= row_d[r];
            end
        end
    end

    // ---------------- Stage 3: total and saturation ----------------
    always_comb begin
        acc_d   = 20'(row_q[0]) + 20'(row_q[1]) + 20'(row_q[2]);
        shifted = acc_d >>> SHIFT;
        if (acc_d < 0) begin
            pix_d = '0;
        end else if (shifted > 20'sd255) begin
            pix_d = 8'hFF;
        end else begin
            pix_d = shifted[7:0];
        end
    end

    // Result registers only load on valid data so outputs hold between passes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid_q <= 1'b0;
            acc_q      <= '0;
            pix_q      <= '0;
            col_q      <= '0;
        end else begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                acc_q <= acc_d;
                pix_q <= pix_d;
                col_q <= s2_col_q;
            end
        end
    end

    assign bus.ALU_en       = alu_en;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.result_valid = s3_valid_q;
    assign bus.acc          = acc_q;
    assign bus.pix_out      = pix_q;
    assign bus.col_idx      = col_q;

endmodule

// File: tb/tb_conv3x3_alu.sv
// Randomised scoreboard bench for conv3x3_alu: two instances (SHIFT 0 and 4) share stimulus,
// expected results come from a sliding-image convolution model.
module tb_conv3x3_alu;
    localparam int COLS = 26;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv3x3_alu_if bus0 ();
    conv3x3_alu_if bus4 ();

    assign bus4.start     = bus0.start;
    assign bus4.w_load_en = bus0.w_load_en;
    assign bus4.w_idx     = bus0.w_idx;
    assign bus4.w_data    = bus0.w_data;
    assign bus4.X_reg1    = bus0.X_reg1;
    assign bus4.X_reg2    = bus0.X_reg2;
    assign bus4.X_reg3    = bus0.X_reg3;

    conv3x3_alu #(.COLS(COLS), .SHIFT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    conv3x3_alu #(.COLS(COLS), .SHIFT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct {
        int acc;
        int col;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t e_m;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   wm [9];
    int   img [3][COLS+2];
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampf(input int a, input int sh);
        int s;
        if (a < 0) return 0;
        s = a >>> sh;
        return (s > 255) ? 255 : s;
    endfunction

    // Convolution of the 3x3 image patch starting at column k.
    function automatic int model_acc(input int k);
        int s = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s += img[r][k+c] * wm[3*r+c];
        return s;
    endfunction

    function automatic logic [23:0] win(input int r, input int k);
        logic [7:0] a, b, c;
        a = img[r][k][7:0];
        b = img[r][k+1][7:0];
        c = img[r][k+2][7:0];
        return {a, b, c};
    endfunction

    task automatic set_window(input int k);
        bus0.X_reg1 = win(0, k);
        bus0.X_reg2 = win(1, k);
        bus0.X_reg3 = win(2, k);
    endtask

    task automatic fill_img(input int mode, input int val);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < COLS + 2; c++)
                img[r][c] = (mode == 0) ? val : int'($urandom_range(0, 255));
    endtask

    task automatic load_w(input int idx, input logic [7:0] d);
        @(posedge clk) #1;
        bus0.w_load_en = 1'b1;
        bus0.w_idx     = 4'(idx);
        bus0.w_data    = d;
        @(posedge clk) #1;
        bus0.w_load_en = 1'b0;
        if (idx < 9) wm[idx] = int'($signed(d));
    endtask

    task automatic load_all(input logic [7:0] d);
        for (int i = 0; i < 9; i++) load_w(i, d);
    endtask

    task automatic load_random();
        for (int i = 0; i < 9; i++) load_w(i, 8'($urandom_range(0, 255)));
    endtask

    // One row pass; optional in-run disturbance, load-with-start, or abort via reset.
    task automatic run_pass(input bit disturb, input bit lws, input int li,
                            input logic [7:0] ld, input int abort_at);
        int  k, alu, t;
        bit  seen;
        k = 0; alu = 0; t = 0; seen = 1'b0;
        set_window(0);
        @(posedge clk) #1;
        bus0.start = 1'b1;
        if (lws) begin
            bus0.w_load_en = 1'b1;
            bus0.w_idx     = 4'(li);
            bus0.w_data    = ld;
            if (li < 9) wm[li] = int'($signed(ld));
        end
        @(posedge clk) #1;
        bus0.start     = 1'b0;
        bus0.w_load_en = 1'b0;
        while (!seen && t < COLS + 20) begin
            @(negedge clk);
            t++;
            if (bus0.done) seen = 1'b1;
            if (bus0.ALU_en) begin
                q.push_back(exp_t'{model_acc(k), k, cyc});
                alu++;
            end
            @(posedge clk) #1;
            bus0.start     = 1'b0;
            bus0.w_load_en = 1'b0;
            if (abort_at > 0 && alu == abort_at) begin
                rst = 1'b1;
                return;
            end
            if (disturb && alu == 3) begin
                bus0.start     = 1'b1;
                bus0.w_load_en = 1'b1;
                bus0.w_idx     = 4'd0;
                bus0.w_data    = 8'h55;
            end
            if (alu > k) begin
                k = alu;
                if (k < COLS) set_window(k);
            end
        end
        check("pass_alu_en_cycles", alu, COLS);
        check("pass_done_seen", int'(seen), 1);
        check("pass_queue_drained", q.size(), 0);
    endtask

    // Monitor: pops the scoreboard whenever the SHIFT=0 instance presents a result.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (bus0.result_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_result_valid", 1, 0);
                end else begin
                    e_m = q.pop_front();
                    check("acc", bus0.acc, e_m.acc);
                    check("pix_out_shift0", int'(bus0.pix_out), clampf(e_m.acc, 0));
                    check("col_idx", int'(bus0.col_idx), e_m.col);
                    check("latency", cyc, e_m.cyc + 3);
                    check("shift4_valid", int'(bus4.result_valid), 1);
                    check("shift4_acc", bus4.acc, e_m.acc);
                    check("pix_out_shift4", int'(bus4.pix_out), clampf(e_m.acc, 4));
                end
            end
            if (bus0.done) begin
                done_cnt++;
                check("done_after_last_valid", int'(prev_valid), 1);
                check("done_not_with_valid", int'(bus0.result_valid), 0);
            end
            prev_valid <= bus0.result_valid;
        end
    end

    initial begin
        int d0;
        bus0.start = 1'b0; bus0.w_load_en = 1'b0; bus0.w_idx = '0; bus0.w_data = '0;
        bus0.X_reg1 = '0; bus0.X_reg2 = '0; bus0.X_reg3 = '0;
        for (int i = 0; i < 9; i++) wm[i] = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_alu_en", int'(bus0.ALU_en), 0);
        check("rst_busy", int'(bus0.busy), 0);
        check("rst_result_valid", int'(bus0.result_valid), 0);
        check("rst_done", int'(bus0.done), 0);
        check("rst_acc", bus0.acc, 0);
        check("rst_pix_out", int'(bus0.pix_out), 0);
        check("rst_col_idx", int'(bus0.col_idx), 0);
        @(posedge clk) #1 rst = 1'b0;

        // Saturating-high pass: all ones over white pixels
        load_all(8'd1);
        fill_img(0, 255);
        run_pass(1'b0, 1'b0, 0, 8'd0, 0);

        // Centre tap only
        load_all(8'd0);
        load_w(4, 8'd1);
        fill_img(0, 0);
        for (int c = 0; c < COLS + 2; c++) img[1][c] = 8'h7B;
        run_pass(1'b0, 1'b0, 0, 8'd0, 0);

        // Most negative sum
        load_all(8'h80);
        fill_img(0, 255);
        run_pass(1'b0, 1'b0, 0, 8'd0, 0);

        // 144 >>> 4 = 9 on the SHIFT=4 instance
        load_all(8'd1);
        fill_img(0, 8'h10);
        run_pass(1'b0, 1'b0, 0, 8'd0, 0);

        // Out-of-range indices are ignored, then random kernels/images
        for (int i = 9; i < 16; i++) load_w(i, 8'($urandom_range(0, 255)));
        fill_img(1, 0);
        run_pass(1'b0, 1'b0, 0, 8'd0, 0);
        load_random();
        load_w(0, 8'h80);
        load_w(8, 8'h7F);
        fill_img(1, 0);
        run_pass(1'b0, 1'b0, 0, 8'd0, 0);

        // Weight written in the start cycle is used from the first window
        fill_img(1, 0);
        run_pass(1'b0, 1'b1, 4, 8'($urandom_range(0, 255)), 0);

        // start / w_load_en during RUN have no effect
        load_random();
        fill_img(1, 0);
        run_pass(1'b1, 1'b0, 0, 8'd0, 0);

        // Reset five cycles into RUN
        load_random();
        fill_img(1, 0);
        d0 = done_cnt;
        run_pass(1'b0, 1'b0, 0, 8'd0, 5);
        @(posedge clk) #1 rst = 1'b0;
        q.delete();
        for (int i = 0; i < 9; i++) wm[i] = 0;
        @(negedge clk);
        check("abort_alu_en", int'(bus0.ALU_en), 0);
        check("abort_busy", int'(bus0.busy), 0);
        check("abort_result_valid", int'(bus0.result_valid), 0);
        repeat (8) @(negedge clk);
        check("abort_no_done", done_cnt, d0);

        // Kernel cleared by reset, then a fresh random pass
        fill_img(1, 0);
        run_pass(1'b0, 1'b0, 0, 8'd0, 0);
        load_random();
        fill_img(1, 0);
        run_pass(1'b0, 1'b0, 0, 8'd0, 0);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
